load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 18 +
 rtl/lsu_lane_merge.sv | 28 ++
 rtl/load_store_unit.sv | 141 ++++++++++++++
 tb/tb_load_store_unit.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//   lsu_state_e : controller states
//   SIZE_WORD / SIZE_BYTE : req_size encodings
//   WORD_BYTES : bytes touched by every memory access
package lsu_pkg;

    localparam int   WORD_BYTES = 4;
    localparam logic SIZE_WORD  = 1'b0;
    localparam logic SIZE_BYTE  = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } lsu_state_e;

endpackage

// File: rtl/lsu_lane_merge.sv
// Combinational byte-lane handling for the load/store unit.
//   size_i      : access size (SIZE_WORD / SIZE_BYTE)
//   sign_i      : sign-extend byte loads when 1
//   captured_i  : word read from memory at the access address
//   wdata_i     : store data from the request
//   store_wd_o  : word to write back (byte store keeps upper captured bytes)
//   load_data_o : load result, word or extended byte
module lsu_lane_merge
    import lsu_pkg::*;
(
    input  logic        size_i,
    input  logic        sign_i,
    input  logic [31:0] captured_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] store_wd_o,
    output logic [31:0] load_data_o
);

    always_comb begin
        store_wd_o  = wdata_i;
        load_data_o = captured_i;
        if (size_i == SIZE_BYTE) begin
            store_wd_o  = {captured_i[31:8], wdata_i[7:0]};
            load_data_o = {{24{sign_i & captured_i[7]}}, captured_i[7:0]};
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one word or byte request at a time, accesses a
// 4-byte-wide memory port (combinational read, posedge write) and returns
// a response. Byte stores are read-modify-write.
// Optional feature macro: SIGNED_LOAD_EN adds req_signed for sign-extended
// byte loads.
//   clk, reset                         : clock, synchronous active-high reset
//   req_valid/req_ready                : request handshake
//   req_we, req_size, req_addr, req_wdata (, req_signed) : request fields
//   resp_valid/resp_ready              : response handshake
//   resp_rdata, resp_err               : load data, out-of-range flag
//   mem_addr, mem_we, mem_wd, mem_rd   : memory port
//
// state | meaning
// IDLE  | ready for a request; mem_addr follows req_addr
// READ  | capture the memory word at the latched address
// WRITE | one-cycle memory write of the (merged) store word
// RESP  | hold response until resp_ready
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int MEM_BYTES  = 20
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic                  req_size,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
`ifdef SIGNED_LOAD_EN
    input  logic                  req_signed,
`endif
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [31:0]           mem_wd,
    input  logic [31:0]           mem_rd
);

    // Highest legal start address: every access touches WORD_BYTES bytes.
    localparam logic [ADDR_WIDTH-1:0] MAX_ADDR = ADDR_WIDTH'(MEM_BYTES - WORD_BYTES);

    lsu_state_e            state_q, state_d;
    logic                  we_q, size_q, err_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wdata_q, captured_q;
    logic                  load_signed;
    logic                  accept, addr_err;
    logic [31:0]           store_wd, load_data;

    assign accept   = req_valid && (state_q == IDLE);
    assign addr_err = req_addr > MAX_ADDR;

`ifdef SIGNED_LOAD_EN
    logic signed_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            signed_q <= 1'b0;
        end else if (accept) begin
            signed_q <= req_signed;
        end
    end
    assign load_signed = signed_q;
`else
    assign load_signed = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            we_q       <= 1'b0;
            size_q     <= SIZE_WORD;
            err_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            captured_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                we_q    <= req_we;
                size_q  <= req_size;
                err_q   <= addr_err;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (state_q == READ) begin
                captured_q <= mem_rd;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (addr_err) begin
                        state_d = RESP;
                    end else if (req_we && (req_size == SIZE_WORD)) begin
                        state_d = WRITE;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ:    state_d = we_q ? WRITE : RESP;
            WRITE:   state_d = RESP;
            RESP:    if (resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    lsu_lane_merge u_lane_merge (
        .size_i      (size_q),
        .sign_i      (load_signed),
        .captured_i  (captured_q),
        .wdata_i     (wdata_q),
        .store_wd_o  (store_wd),
        .load_data_o (load_data)
    );

    always_comb begin
        req_ready  = (state_q == IDLE);
        resp_valid = (state_q == RESP);
        resp_err   = (state_q == RESP) && err_q;
        resp_rdata = '0;
        if ((state_q == RESP) && !we_q && !err_q) begin
            resp_rdata = load_data;
        end
        mem_addr = (state_q == IDLE) ? req_addr : addr_q;
        // A reset landing on the WRITE cycle must not commit the write.
        mem_we   = (state_q == WRITE) && !reset;
        mem_wd   = store_wd;
    end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    localparam int AW = 12;
    localparam int MB = 20;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid, req_ready, req_we, req_size;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;
`ifdef SIGNED_LOAD_EN
    logic          req_signed;
`endif
    logic          resp_valid, resp_ready, resp_err;
    logic [31:0]   resp_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [31:0]   mem_wd, mem_rd;

    logic [7:0]    mem [MB];
    logic [7:0]    ref_mem [MB];
    logic          mem_init;
    int            we_count;
    logic [31:0]   last_wd;

    int   vectors     = 0;
    int   miscompares = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_WIDTH(AW), .MEM_BYTES(MB)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
`ifdef SIGNED_LOAD_EN
        .req_signed (req_signed),
`endif
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wd     (mem_wd),
        .mem_rd     (mem_rd)
    );

    // Memory: combinational little-endian 4-byte read, posedge 4-byte write.
    always_comb begin
        mem_rd = '0;
        for (int k = 0; k < 4; k++) begin
            if (int'(mem_addr) + k < MB) mem_rd[8*k +: 8] = mem[int'(mem_addr) + k];
        end
    end

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < MB; i++) mem[i] <= 8'(8'h10 + i);
            we_count <= 0;
            last_wd  <= '0;
        end else if (mem_we) begin
            we_count <= we_count + 1;
            last_wd  <= mem_wd;
            for (int k = 0; k < 4; k++) begin
                if (int'(mem_addr) + k < MB) mem[int'(mem_addr) + k] <= mem_wd[8*k +: 8];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input int a);
        return {ref_mem[a+3], ref_mem[a+2], ref_mem[a+1], ref_mem[a]};
    endfunction

    task automatic do_req(input logic we, input logic size, input int addr,
                          input logic [31:0] wdata, input logic sgn,
                          input int stall, input string tag);
        exp_t        e;
        exp_t        got;
        logic        err;
        logic [31:0] wexp;
        int          lat_exp, n, cnt0, we_exp;
        logic        ext;
        err  = addr > MB - 4;
        wexp = '0;
`ifdef SIGNED_LOAD_EN
        ext = sgn;
`else
        ext = 1'b0;
`endif
        e.err   = err;
        e.rdata = '0;
        if (!err && !we) begin
            if (size) e.rdata = {{24{ext & ref_mem[addr][7]}}, ref_mem[addr]};
            else      e.rdata = ref_word(addr);
        end
        if (!err && we) begin
            if (size) ref_mem[addr] = wdata[7:0];
            else for (int k = 0; k < 4; k++) ref_mem[addr+k] = wdata[8*k +: 8];
            wexp = ref_word(addr);
        end
        lat_exp = err ? 1 : ((we && size) ? 3 : 2);
        we_exp  = (we && !err) ? 1 : 0;
        sb.push_back(e);
        cnt0 = we_count;

        @(negedge clk);
        check({tag, ".req_ready"}, 32'(req_ready), 32'd1);
        resp_ready = (stall == 0);
        req_valid  = 1'b1;
        req_we     = we;
        req_size   = size;
        req_addr   = AW'(addr);
        req_wdata  = wdata;
`ifdef SIGNED_LOAD_EN
        req_signed = sgn;
`endif
        @(negedge clk);
        // Garbage on the request bus after acceptance must be ignored.
        req_valid = 1'b0;
        req_we    = 1'($urandom);
        req_size  = 1'($urandom);
        req_addr  = AW'($urandom);
        req_wdata = $urandom;
        n = 1;
        while (!resp_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        check({tag, ".latency"}, resp_valid ? 32'(n) : 32'hFFFF_FFFF, 32'(lat_exp));
        got = sb.pop_front();
        if (resp_valid) begin
            check({tag, ".rdata"}, resp_rdata, got.rdata);
            check({tag, ".err"}, 32'(resp_err), 32'(got.err));
            for (int s = 0; s < stall; s++) begin
                @(negedge clk);
                check({tag, ".hold_valid"}, 32'(resp_valid), 32'd1);
                check({tag, ".hold_rdata"}, resp_rdata, got.rdata);
                check({tag, ".hold_ready"}, 32'(req_ready), 32'd0);
            end
            resp_ready = 1'b1;
            @(negedge clk);
            check({tag, ".idle_ready"}, 32'(req_ready), 32'd1);
            check({tag, ".idle_valid"}, 32'(resp_valid), 32'd0);
        end
        check({tag, ".we_pulses"}, 32'(we_count - cnt0), 32'(we_exp));
        if (we_exp == 1) check({tag, ".mem_wd"}, last_wd, wexp);
    endtask

    initial begin
        int cnt0;
        for (int i = 0; i < MB; i++) ref_mem[i] = 8'(8'h10 + i);
        reset      = 1'b1;
        mem_init   = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_size   = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        resp_ready = 1'b1;
`ifdef SIGNED_LOAD_EN
        req_signed = 1'b0;
`endif
        repeat (2) @(negedge clk);
        reset    = 1'b0;
        mem_init = 1'b0;

        check("rst.req_ready", 32'(req_ready), 32'd1);
        check("rst.resp_valid", 32'(resp_valid), 32'd0);
        check("rst.resp_err", 32'(resp_err), 32'd0);
        check("rst.resp_rdata", resp_rdata, 32'd0);
        check("rst.mem_we", 32'(mem_we), 32'd0);

        do_req(1'b1, 1'b0, 0, 32'hDDCC_BBAA, 1'b0, 0, "st_w0");
        do_req(1'b0, 1'b0, 0, 32'h0, 1'b0, 0, "ld_w0");
        for (int a = 0; a < 4; a++) do_req(1'b0, 1'b1, a, 32'h0, 1'b0, 0, "ld_b");
        check("ld_b.ref1", 32'(ref_mem[1]), 32'hBB);
        do_req(1'b1, 1'b1, 1, 32'h1234_5655, 1'b0, 0, "st_b1");
        do_req(1'b0, 1'b0, 0, 32'h0, 1'b0, 0, "ld_w0_merged");
        check("ld_w0_merged.ref", ref_word(0), 32'hDDCC_55AA);
        do_req(1'b1, 1'b1, 5, 32'h0000_0080, 1'b0, 0, "st_b5");
        do_req(1'b0, 1'b1, 5, 32'h0, 1'b0, 0, "ld_b5_u");
        do_req(1'b0, 1'b1, 5, 32'h0, 1'b1, 0, "ld_b5_s");
        do_req(1'b0, 1'b0, 17, 32'h0, 1'b0, 0, "ld_w17_err");
        do_req(1'b0, 1'b0, 16, 32'h0, 1'b0, 0, "ld_w16_ok");
        do_req(1'b1, 1'b0, 17, 32'hCAFE_F00D, 1'b0, 0, "st_w17_err");
        do_req(1'b1, 1'b1, 19, 32'h0000_00EE, 1'b0, 0, "st_b19_err");
        do_req(1'b0, 1'b0, 0, 32'h0, 1'b0, 5, "ld_w0_stall");

        // Reset during the WRITE cycle of a byte store.
        cnt0 = we_count;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_size  = 1'b1;
        req_addr  = AW'(1);
        req_wdata = 32'h0000_00A5;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("rstw.in_write", 32'(mem_we), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rstw.req_ready", 32'(req_ready), 32'd1);
        check("rstw.resp_valid", 32'(resp_valid), 32'd0);
        check("rstw.no_write", 32'(we_count - cnt0), 32'd0);
        check("rstw.mem1", 32'(mem[1]), 32'(ref_mem[1]));
        @(negedge clk);
        check("rstw.resp_valid2", 32'(resp_valid), 32'd0);

        do_req(1'b1, 1'b0, 16, 32'h1234_5678, 1'b0, 0, "st_w16");
        do_req(1'b0, 1'b0, 16, 32'h0, 1'b0, 0, "ld_w16");
        do_req(1'b0, 1'b1, 18, 32'h0, 1'b0, 0, "ld_b18");

        for (int i = 0; i < MB; i++) check($sformatf("mem[%0d]", i), 32'(mem[i]), 32'(ref_mem[i]));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
